// File: rtl/fetch_issue_unit.sv
// fetch_issue_unit
//   Producer end of the fetch-to-decode interface. Buffers up to two aligned
//   4-instruction fetch blocks in a two-entry ring and serialises them, one
//   instruction per cycle, onto the decode input bus. Each issued instruction
//   gets a unique major ID from a free-running counter.
//
// Ports
//   clock_i, reset_i          clock / asynchronous active-low reset
//   flush_i                   discard buffered and pending instructions
//   stall_i                   decode stall; issue outputs hold while high
//   blockValid_i/blockReady_o fetch block handshake
//   block_i                   four instruction words, word 0 in bits [0:31]
//   blockAddress_i            address of first valid word ([60:61] = slot)
//   blockIs64Bit_i, blockPid_i, blockTid_i   per-block attributes
//   enable_o ... instructionMajId_o          registered issue bus
//
// Bit numbering follows the POWER convention: bit 0 is the MSB.
module fetch_issue_unit #(
  parameter int addressWidth            = 64,
  parameter int instructionWidth        = 32,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int instructionCounterWidth = 64,
  parameter int blockInsts              = 4
) (
  input  logic                                      clock_i,
  input  logic                                      reset_i,
  input  logic                                      flush_i,
  input  logic                                      stall_i,
  input  logic                                      blockValid_i,
  output logic                                      blockReady_o,
  input  logic [0:blockInsts*instructionWidth-1]    block_i,
  input  logic [0:addressWidth-1]                   blockAddress_i,
  input  logic                                      blockIs64Bit_i,
  input  logic [PidSize-1:0]                        blockPid_i,
  input  logic [TidSize-1:0]                        blockTid_i,
  output logic                                      enable_o,
  output logic [0:instructionWidth-1]               instruction_o,
  output logic [0:addressWidth-1]                   instructionAddress_o,
  output logic                                      is64Bit_o,
  output logic [PidSize-1:0]                        instructionPid_o,
  output logic [TidSize-1:0]                        instructionTid_o,
  output logic [instructionCounterWidth-1:0]        instructionMajId_o
);

  localparam int BlkW  = blockInsts * instructionWidth;
  localparam int BaseW = addressWidth - 4;

  // Address bits [62:63] are byte offsets within a word and carry no meaning.
  logic unused_addr_bits;
  assign unused_addr_bits = ^blockAddress_i[addressWidth-2:addressWidth-1];

  // Slot payload: written on accept only, never needs a reset value.
  logic [0:BlkW-1]    slot_data_q [2];
  logic [0:BaseW-1]   slot_base_q [2];
  logic               slot_is64_q [2];
  logic [PidSize-1:0] slot_pid_q  [2];
  logic [TidSize-1:0] slot_tid_q  [2];

  // Control state.
  logic [1:0] slot_vld_q, slot_vld_d;
  logic [1:0] slot_idx_q [2];
  logic [1:0] slot_idx_d [2];
  logic       head_q, head_d;
  logic [instructionCounterWidth-1:0] cnt_q, cnt_d;

  // Registered issue bus.
  logic                               enable_q, enable_d;
  logic [0:instructionWidth-1]        instr_q, instr_d;
  logic [0:addressWidth-1]            addr_q, addr_d;
  logic                               is64_q, is64_d;
  logic [PidSize-1:0]                 pid_q, pid_d;
  logic [TidSize-1:0]                 tid_q, tid_d;
  logic [instructionCounterWidth-1:0] majid_q, majid_d;

  logic tail;
  logic accept;
  logic ready;

  function automatic logic [0:instructionWidth-1] pick_word(
    input logic [0:BlkW-1] blk,
    input logic [1:0]      idx
  );
    return blk[int'(idx)*instructionWidth +: instructionWidth];
  endfunction

  // The only valid slot is always the head (the head advances exactly when
  // its slot empties), so the tail is the head when it is free, else the
  // other slot.
  assign tail   = slot_vld_q[head_q] ? ~head_q : head_q;
  assign ready  = (slot_vld_q != 2'b11);
  assign accept = blockValid_i && ready && !flush_i;

  always_comb begin
    slot_vld_d = slot_vld_q;
    slot_idx_d = slot_idx_q;
    head_d     = head_q;
    cnt_d      = cnt_q;
    enable_d   = enable_q;
    instr_d    = instr_q;
    addr_d     = addr_q;
    is64_d     = is64_q;
    pid_d      = pid_q;
    tid_d      = tid_q;
    majid_d    = majid_q;

    if (flush_i) begin
      slot_vld_d = 2'b00;
      enable_d   = 1'b0;
    end else begin
      if (!stall_i) begin
        if (slot_vld_q[head_q]) begin
          enable_d = 1'b1;
          instr_d  = pick_word(slot_data_q[head_q], slot_idx_q[head_q]);
          addr_d   = {slot_base_q[head_q], slot_idx_q[head_q], 2'b00};
          is64_d   = slot_is64_q[head_q];
          pid_d    = slot_pid_q[head_q];
          tid_d    = slot_tid_q[head_q];
          majid_d  = cnt_q;
          cnt_d    = cnt_q + instructionCounterWidth'(1);
          slot_idx_d[head_q] = slot_idx_q[head_q] + 2'd1;
          // Last word of the block: retire the slot so the other one
          // issues on the very next edge.
          if (slot_idx_q[head_q] == 2'd3) begin
            slot_vld_d[head_q] = 1'b0;
            head_d             = ~head_q;
          end
        end else begin
          enable_d = 1'b0;
        end
      end
      // Accept targets the tail, which differs from the issuing head slot
      // whenever the head is valid, so these updates never collide.
      if (accept) begin
        slot_vld_d[tail] = 1'b1;
        slot_idx_d[tail] = blockAddress_i[addressWidth-4:addressWidth-3];
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      slot_vld_q    <= 2'b00;
      slot_idx_q[0] <= 2'd0;
      slot_idx_q[1] <= 2'd0;
      head_q        <= 1'b0;
      cnt_q         <= '0;
      enable_q      <= 1'b0;
      instr_q       <= '0;
      addr_q        <= '0;
      is64_q        <= 1'b0;
      pid_q         <= '0;
      tid_q         <= '0;
      majid_q       <= '0;
    end else begin
      slot_vld_q <= slot_vld_d;
      slot_idx_q <= slot_idx_d;
      head_q     <= head_d;
      cnt_q      <= cnt_d;
      enable_q   <= enable_d;
      instr_q    <= instr_d;
      addr_q     <= addr_d;
      is64_q     <= is64_d;
      pid_q      <= pid_d;
      tid_q      <= tid_d;
      majid_q    <= majid_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (accept) begin
      slot_data_q[tail] <= block_i;
      slot_base_q[tail] <= blockAddress_i[0:BaseW-1];
      slot_is64_q[tail] <= blockIs64Bit_i;
      slot_pid_q[tail]  <= blockPid_i;
      slot_tid_q[tail]  <= blockTid_i;
    end
  end

  assign blockReady_o         = ready;
  assign enable_o             = enable_q;
  assign instruction_o        = instr_q;
  assign instructionAddress_o = addr_q;
  assign is64Bit_o            = is64_q;
  assign instructionPid_o     = pid_q;
  assign instructionTid_o     = tid_q;
  assign instructionMajId_o   = majid_q;

endmodule

// File: tb/tb_fetch_issue_unit.sv
module tb_fetch_issue_unit;

  logic          clock_i = 1'b0;
  logic          reset_i;
  logic          flush_i;
  logic          stall_i;
  logic          blockValid_i;
  logic          blockReady_o;
  logic [0:127]  block_i;
  logic [0:63]   blockAddress_i;
  logic          blockIs64Bit_i;
  logic [19:0]   blockPid_i;
  logic [15:0]   blockTid_i;
  logic          enable_o;
  logic [0:31]   instruction_o;
  logic [0:63]   instructionAddress_o;
  logic          is64Bit_o;
  logic [19:0]   instructionPid_o;
  logic [15:0]   instructionTid_o;
  logic [63:0]   instructionMajId_o;

  int tests = 0;
  int fails = 0;

  logic [19:0] exp_pid;
  logic [15:0] exp_tid;
  logic        exp_is64;

  fetch_issue_unit dut (
    .clock_i              (clock_i),
    .reset_i              (reset_i),
    .flush_i              (flush_i),
    .stall_i              (stall_i),
    .blockValid_i         (blockValid_i),
    .blockReady_o         (blockReady_o),
    .block_i              (block_i),
    .blockAddress_i       (blockAddress_i),
    .blockIs64Bit_i       (blockIs64Bit_i),
    .blockPid_i           (blockPid_i),
    .blockTid_i           (blockTid_i),
    .enable_o             (enable_o),
    .instruction_o        (instruction_o),
    .instructionAddress_o (instructionAddress_o),
    .is64Bit_o            (is64Bit_o),
    .instructionPid_o     (instructionPid_o),
    .instructionTid_o     (instructionTid_o),
    .instructionMajId_o   (instructionMajId_o)
  );

  always #5 clock_i = ~clock_i;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_issue(input string tag, input logic [31:0] instr,
                           input logic [63:0] addr, input logic [63:0] id);
    chk({tag, ".en"},   64'(enable_o), 64'd1);
    chk({tag, ".ins"},  64'(instruction_o), 64'(instr));
    chk({tag, ".addr"}, 64'(instructionAddress_o), addr);
    chk({tag, ".id"},   instructionMajId_o, id);
    chk({tag, ".pid"},  64'(instructionPid_o), 64'(exp_pid));
    chk({tag, ".tid"},  64'(instructionTid_o), 64'(exp_tid));
    chk({tag, ".m64"},  64'(is64Bit_o), 64'(exp_is64));
  endtask

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic offer(input logic [63:0] addr, input logic [31:0] wbase,
                       input logic [19:0] pid, input logic [15:0] tid, input logic m64);
    logic [31:0] w1, w2, w3;
    w1 = wbase + 32'd1;
    w2 = wbase + 32'd2;
    w3 = wbase + 32'd3;
    blockValid_i   = 1'b1;
    block_i        = {wbase, w1, w2, w3};
    blockAddress_i = addr;
    blockPid_i     = pid;
    blockTid_i     = tid;
    blockIs64Bit_i = m64;
  endtask

  initial begin
    reset_i        = 1'b0;
    flush_i        = 1'b0;
    stall_i        = 1'b0;
    blockValid_i   = 1'b0;
    block_i        = '0;
    blockAddress_i = '0;
    blockIs64Bit_i = 1'b0;
    blockPid_i     = '0;
    blockTid_i     = '0;

    // Reset state
    #2;
    chk("rst.en", 64'(enable_o), 64'd0);
    chk("rst.id", instructionMajId_o, 64'd0);
    chk("rst.addr", 64'(instructionAddress_o), 64'd0);
    step();
    step();
    reset_i = 1'b1;
    #1;
    chk("rst.ready", 64'(blockReady_o), 64'd1);

    // 1: full block from slot 0
    exp_pid = 20'h12345; exp_tid = 16'h0007; exp_is64 = 1'b1;
    offer(64'h1000, 32'hA000_0000, exp_pid, exp_tid, exp_is64);
    step();
    blockValid_i = 1'b0;
    chk("t1.lat", 64'(enable_o), 64'd0);
    step(); chk_issue("t1.i0", 32'hA000_0000, 64'h1000, 64'd0);
    step(); chk_issue("t1.i1", 32'hA000_0001, 64'h1004, 64'd1);
    step(); chk_issue("t1.i2", 32'hA000_0002, 64'h1008, 64'd2);
    step(); chk_issue("t1.i3", 32'hA000_0003, 64'h100C, 64'd3);
    step();
    chk("t1.idle", 64'(enable_o), 64'd0);
    chk("t1.hold", instructionMajId_o, 64'd3);

    // 2: block starting at slot 2
    exp_pid = 20'h00ABC; exp_tid = 16'h1234; exp_is64 = 1'b0;
    offer(64'h2008, 32'hB000_0000, exp_pid, exp_tid, exp_is64);
    step();
    blockValid_i = 1'b0;
    step(); chk_issue("t2.i2", 32'hB000_0002, 64'h2008, 64'd4);
    step(); chk_issue("t2.i3", 32'hB000_0003, 64'h200C, 64'd5);
    step();
    chk("t2.idle", 64'(enable_o), 64'd0);

    // 3: back-to-back blocks, third offer held off until a slot frees
    exp_pid = 20'h00011; exp_tid = 16'h0022; exp_is64 = 1'b1;
    offer(64'h3000, 32'hC000_0000, exp_pid, exp_tid, exp_is64);
    step();
    chk("t3.rdyA", 64'(blockReady_o), 64'd1);
    offer(64'h3010, 32'hD000_0000, exp_pid, exp_tid, exp_is64);
    step(); chk_issue("t3.c0", 32'hC000_0000, 64'h3000, 64'd6);
    chk("t3.rdyB", 64'(blockReady_o), 64'd0);
    offer(64'h4000, 32'hE000_0000, exp_pid, exp_tid, exp_is64);
    step(); chk_issue("t3.c1", 32'hC000_0001, 64'h3004, 64'd7);
    chk("t3.rdyC", 64'(blockReady_o), 64'd0);
    step(); chk_issue("t3.c2", 32'hC000_0002, 64'h3008, 64'd8);
    chk("t3.rdyD", 64'(blockReady_o), 64'd0);
    step(); chk_issue("t3.c3", 32'hC000_0003, 64'h300C, 64'd9);
    chk("t3.rdyE", 64'(blockReady_o), 64'd1);
    step(); chk_issue("t3.d0", 32'hD000_0000, 64'h3010, 64'd10);
    chk("t3.rdyF", 64'(blockReady_o), 64'd0);
    blockValid_i = 1'b0;
    step(); chk_issue("t3.d1", 32'hD000_0001, 64'h3014, 64'd11);
    step(); chk_issue("t3.d2", 32'hD000_0002, 64'h3018, 64'd12);
    step(); chk_issue("t3.d3", 32'hD000_0003, 64'h301C, 64'd13);
    chk("t3.rdyI", 64'(blockReady_o), 64'd1);
    step(); chk_issue("t3.e0", 32'hE000_0000, 64'h4000, 64'd14);
    step(); chk_issue("t3.e1", 32'hE000_0001, 64'h4004, 64'd15);
    step(); chk_issue("t3.e2", 32'hE000_0002, 64'h4008, 64'd16);
    step(); chk_issue("t3.e3", 32'hE000_0003, 64'h400C, 64'd17);
    step();
    chk("t3.idle", 64'(enable_o), 64'd0);

    // 4: stall after the second issue
    exp_pid = 20'hFFFFF; exp_tid = 16'hFFFF; exp_is64 = 1'b0;
    offer(64'h5000, 32'hF000_0000, exp_pid, exp_tid, exp_is64);
    step();
    blockValid_i = 1'b0;
    step(); chk_issue("t4.f0", 32'hF000_0000, 64'h5000, 64'd18);
    step(); chk_issue("t4.f1", 32'hF000_0001, 64'h5004, 64'd19);
    stall_i = 1'b1;
    step(); chk_issue("t4.s1", 32'hF000_0001, 64'h5004, 64'd19);
    step(); chk_issue("t4.s2", 32'hF000_0001, 64'h5004, 64'd19);
    step(); chk_issue("t4.s3", 32'hF000_0001, 64'h5004, 64'd19);
    stall_i = 1'b0;
    step(); chk_issue("t4.f2", 32'hF000_0002, 64'h5008, 64'd20);
    step(); chk_issue("t4.f3", 32'hF000_0003, 64'h500C, 64'd21);
    step();
    chk("t4.idle", 64'(enable_o), 64'd0);

    // 5: flush with a partly issued block and a queued block
    exp_pid = 20'h00005; exp_tid = 16'h0005; exp_is64 = 1'b1;
    offer(64'h6000, 32'h1600_0000, exp_pid, exp_tid, exp_is64);
    step();
    offer(64'h7000, 32'h1700_0000, exp_pid, exp_tid, exp_is64);
    step(); chk_issue("t5.g0", 32'h1600_0000, 64'h6000, 64'd22);
    blockValid_i = 1'b0;
    step(); chk_issue("t5.g1", 32'h1600_0001, 64'h6004, 64'd23);
    flush_i = 1'b1;
    offer(64'h8000, 32'h1800_0000, exp_pid, exp_tid, exp_is64);
    step();
    flush_i = 1'b0;
    blockValid_i = 1'b0;
    chk("t5.flush.en", 64'(enable_o), 64'd0);
    chk("t5.flush.rdy", 64'(blockReady_o), 64'd1);
    step();
    chk("t5.empty", 64'(enable_o), 64'd0);
    offer(64'h9000, 32'h1900_0000, exp_pid, exp_tid, exp_is64);
    step();
    blockValid_i = 1'b0;
    step(); chk_issue("t5.i0", 32'h1900_0000, 64'h9000, 64'd24);
    step(); chk_issue("t5.i1", 32'h1900_0001, 64'h9004, 64'd25);

    // 6: asynchronous reset between edges
    #2;
    reset_i = 1'b0;
    #1;
    chk("t6.en", 64'(enable_o), 64'd0);
    chk("t6.ins", 64'(instruction_o), 64'd0);
    chk("t6.addr", 64'(instructionAddress_o), 64'd0);
    chk("t6.id", instructionMajId_o, 64'd0);
    chk("t6.pid", 64'(instructionPid_o), 64'd0);
    chk("t6.tid", 64'(instructionTid_o), 64'd0);
    chk("t6.m64", 64'(is64Bit_o), 64'd0);
    #1;
    reset_i = 1'b1;
    #1;
    chk("t6.rdy", 64'(blockReady_o), 64'd1);
    exp_pid = 20'h0A0A0; exp_tid = 16'h0B0B; exp_is64 = 1'b0;
    offer(64'hA000, 32'h2A00_0000, exp_pid, exp_tid, exp_is64);
    step();
    blockValid_i = 1'b0;
    step(); chk_issue("t6.j0", 32'h2A00_0000, 64'hA000, 64'd0);
    step(); chk_issue("t6.j1", 32'h2A00_0001, 64'hA004, 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_issue_unit.md
Name: fetch_issue_unit

Overview:
- Producer end of the fetch-to-decode interface.
- Accepts aligned 4-instruction fetch blocks from the fetch stage and buffers up to two of them.
- Serialises them one instruction per cycle onto the DecodeUnit input bus, assigning a unique major ID to each instruction and honouring decode stall and flush.

Parameters:
- addressWidth, 64, instruction address width.
- instructionWidth, 32, POWER instruction size in bits.
- PidSize, 20, process ID width.
- TidSize, 16, thread ID width.
- instructionCounterWidth, 64, major ID width.
- blockInsts, 4, instructions per fetch block (fixed at 4; slot index is 2 bits).

Ports:
- clock_i  in  1  clock; all state updates on rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- flush_i  in  1  discard all buffered and pending instructions.
- stall_i  in  1  decode stall; outputs hold while high.
- blockValid_i  in  1  fetch block offered.
- blockReady_o  out  1  unit can accept a block this cycle.
- block_i  in  128  instruction 0 in [0:31], 1 in [32:63], 2 in [64:95], 3 in [96:127].
- blockAddress_i  in  64  address of first valid instruction; bits [60:61] give start slot; [62:63] ignored.
- blockIs64Bit_i  in  1  mode bit for the block.
- blockPid_i  in  PidSize  process ID.
- blockTid_i  in  TidSize  thread ID.
- enable_o  out  1  instruction valid to decode (drives enable_i).
- instruction_o  out  32  instruction word.
- instructionAddress_o  out  64  instruction address.
- is64Bit_o  out  1  mode bit.
- instructionPid_o  out  PidSize  process ID.
- instructionTid_o  out  TidSize  thread ID.
- instructionMajId_o  out  64  major ID.

Behaviour:
- Reset (reset_i=0, asynchronous):
  - All registered outputs go to 0.
  - Both slots empty; head pointer 0; major ID counter 0.
  - blockReady_o=1 once reset is released.
- Storage: two block slots used as a ring. Each slot holds valid, data, base address [0:59], next index (2 bits), is64, pid and tid. A 1-bit head pointer selects the issuing slot.
- Accept:
  - A block is accepted on the rising edge when blockValid_i && blockReady_o && !flush_i.
  - It is written to the tail slot with next index = blockAddress_i[60:61].
  - blockReady_o = (valid slot count < 2), combinational from state.
  - stall_i does not block acceptance.
- Issue (rising edge, !flush_i, !stall_i):
  - If the head slot is valid, register its next instruction onto the outputs and set enable_o=1.
  - instructionAddress_o = {base[0:59], index, 2'b00}. No carry across blocks.
  - instructionMajId_o = counter; counter increments by 1 (wraps modulo 2^64).
  - The index increments. On index 3 the slot is invalidated and the head toggles, so the next slot issues on the following cycle with no bubble.
  - If no valid slot exists, enable_o=0 and the other outputs hold their last values.
- Latency:
  - A block accepted into an empty unit at edge N shows its first instruction on the outputs after edge N+1.
  - A block accepted in the same edge that the head slot empties does not issue that edge.
- Stall (stall_i=1, no flush): every output, including enable_o, holds. No index advance, no ID consumed.
- Flush (flush_i=1):
  - Highest priority over accept, issue and stall.
  - At the edge: both slots invalidated, enable_o=0, blockValid_i ignored.
  - Counter not reset, so IDs stay unique.
- Simultaneous accept and issue in one edge is legal and independent.
- Reset mid-block drops all instructions immediately.

Test Plan:
1. Release reset. Offer a block at 0x1000, words 0xA0000000..0xA0000003, stall_i=0 → enable_o=1 on 4 consecutive cycles, addresses 0x1000/0x1004/0x1008/0x100C, majId 0..3, then enable_o=0.
2. Offer a block at 0x2008 → 2 issues: addresses 0x2008 and 0x200C, words from slots 2 and 3, majId continuing from 4.
3. Offer blocks at 0x3000 and 0x3010 back to back → 8 consecutive issues with no bubble; blockReady_o=0 while two slots are held; a third offer is not accepted until a slot frees.
4. Raise stall_i for 3 cycles after the 2nd issue of a block → outputs identical across those cycles; the resumed stream continues in order with no majId skipped.
5. Pulse flush_i with a partly issued block plus one queued block → enable_o=0 on the next cycle; the next accepted block's first majId = last issued majId + 1.
6. Assert reset_i low mid-block, between clock edges → all outputs 0 immediately; after release, the first issued majId is 0.
